seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: debounces scanned anode/segment samples into an 8-digit frame.
// Frame updates 2 cycles after the input edge of the last digit's qualifying sample; no backpressure.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  input  logic        clear,
  output logic [31:0] frame_out,
  output logic        frame_valid,
  output logic [7:0]  blank_mask,
  output logic        err_invalid,
  output logic        err_multi,
  output logic        stale
);

  localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    STABLE_N     = 4'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_N    = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    CODE_INVALID = 4'hE;
  localparam logic [3:0]    CODE_BLANK   = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  function automatic logic [3:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b1000000: decode_seg = 4'd0;
      7'b1111001: decode_seg = 4'd1;
      7'b0100100: decode_seg = 4'd2;
      7'b0110000: decode_seg = 4'd3;
      7'b0011001: decode_seg = 4'd4;
      7'b0010010: decode_seg = 4'd5;
      7'b0000010: decode_seg = 4'd6;
      7'b1111000: decode_seg = 4'd7;
      7'b0000000: decode_seg = 4'd8;
      7'b0010000: decode_seg = 4'd9;
      7'b1111111: decode_seg = CODE_BLANK;
      default:    decode_seg = CODE_INVALID;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [14:0]   hold_q, hold_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    seen_q, seen_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          done_q, done_d;
  logic [31:0]   frame_q, frame_d;
  logic          fv_q, fv_d;
  logic [7:0]    blank_q, blank_d;
  logic          err_inv_q, err_inv_d;
  logic          err_multi_q, err_multi_d;
  logic          stale_q, stale_d;

  logic [3:0]    zero_cnt;
  logic [2:0]    sel_idx;
  logic          one_hot;
  logic          multi_low;
  logic [14:0]   sample;
  logic          same_sample;
  logic          restart;
  logic [3:0]    cnt_next;
  logic          capture;
  logic [3:0]    cap_code;
  logic [7:0]    cap_mask;
  logic [7:0]    seen_set;
  logic [TW-1:0] to_inc;
  logic          timeout;

  always_comb begin
    an_d  = an;
    seg_d = seg;
  end

  always_comb begin
    zero_cnt = '0;
    sel_idx  = '0;
    for (int i = 0; i < 8; i++) begin
      if (!an_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        sel_idx  = 3'(i);
      end
    end
  end

  assign one_hot     = (zero_cnt == 4'd1);
  assign multi_low   = (zero_cnt > 4'd1);
  assign sample      = {an_q, seg_q};
  assign same_sample = (sample == hold_q);

  // A new dwell starts whenever a one-hot sample differs from the one being tracked.
  always_comb begin
    restart  = one_hot && ((state_q == IDLE) || !same_sample);
    cnt_next = restart ? 4'd1 : (cnt_q + 4'd1);
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    if (!one_hot) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (restart || (state_q == SETTLE)) begin
      cnt_d   = cnt_next;
      state_d = (cnt_next == STABLE_N) ? HELD : SETTLE;
      if (restart) begin
        hold_d = sample;
      end
    end
  end

  always_comb begin
    capture = 1'b0;
    if (one_hot && (restart || (state_q == SETTLE)) && (cnt_next == STABLE_N)) begin
      capture = 1'b1;
    end
  end

  always_comb begin
    cap_code = decode_seg(seg_q);
    cap_mask = capture ? (8'b1 << sel_idx) : 8'b0;

    shadow_d = shadow_q;
    if (capture) begin
      shadow_d[{sel_idx, 2'b00} +: 4] = cap_code;
    end

    // Completion is judged including this cycle's capture, so it beats a coincident timeout.
    seen_set = seen_q | cap_mask;
    done_d   = (seen_set == 8'hFF);
    to_inc   = to_q + TW'(1);
    timeout  = (to_inc == TIMEOUT_N) && !done_d;
    to_d     = (done_d || timeout) ? '0 : to_inc;
    seen_d   = (done_d || timeout) ? 8'h00 : seen_set;

    frame_d = frame_q;
    blank_d = blank_q;
    if (done_q) begin
      frame_d = shadow_q;
      for (int i = 0; i < 8; i++) begin
        blank_d[i] = (shadow_q[4*i +: 4] == CODE_BLANK);
      end
    end
    fv_d = done_q;

    err_inv_d   = (err_inv_q & ~clear) | (capture && (cap_code == CODE_INVALID));
    err_multi_d = (err_multi_q & ~clear) | multi_low;
    stale_d     = (stale_q & ~clear) | timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
      hold_q      <= '1;
      cnt_q       <= '0;
      to_q        <= '0;
      seen_q      <= '0;
      shadow_q    <= '0;
      done_q      <= 1'b0;
      frame_q     <= '0;
      fv_q        <= 1'b0;
      blank_q     <= '0;
      err_inv_q   <= 1'b0;
      err_multi_q <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      an_q        <= an_d;
      seg_q       <= seg_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      seen_q      <= seen_d;
      shadow_q    <= shadow_d;
      done_q      <= done_d;
      frame_q     <= frame_d;
      fv_q        <= fv_d;
      blank_q     <= blank_d;
      err_inv_q   <= err_inv_d;
      err_multi_q <= err_multi_d;
      stale_q     <= stale_d;
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = fv_q;
  assign blank_mask  = blank_q;
  assign err_invalid = err_inv_q;
  assign err_multi   = err_multi_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: run-length reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_seg_scan_decoder;

  localparam int STABLE = 2;
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        clear;
  logic [31:0] frame_out;
  logic        frame_valid;
  logic [7:0]  blank_mask;
  logic        err_invalid;
  logic        err_multi;
  logic        stale;

  seg_scan_decoder #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .an         (an),
    .seg        (seg),
    .clear      (clear),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .blank_mask (blank_mask),
    .err_invalid(err_invalid),
    .err_multi  (err_multi),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  bit          m_ok = 1'b0;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  logic [14:0] m_last;
  bit          m_last_oh;
  int          m_run;
  logic [3:0]  m_slot [8];
  logic [7:0]  m_seen;
  bit          m_pend;
  int          m_to;
  logic [31:0] m_frame;
  logic [7:0]  m_blank;
  bit          m_fv, m_einv, m_emul, m_stale;

  // Frame pulse monitor
  int          fv_count = 0;
  int          fv_cyc   = 0;
  logic [31:0] fv_frame = '0;
  logic [7:0]  fv_blank = '0;
  int          t7       = 0;

  function automatic logic [3:0] m_decode(input logic [6:0] s);
    if (s == 7'h7F) return 4'hF;
    for (int d = 0; d < 10; d++) begin
      if (pat[d] == s) return 4'(d);
    end
    return 4'hE;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] v);
    if (v == 4'hF) return 7'h7F;
    if (v < 4'd10) return pat[v];
    return 7'b1010101;
  endfunction

  always @(posedge clk) begin : model
    int         zeros;
    int         k;
    logic [3:0] code;
    bit         cap, done, tmo;
    cyc++;
    if (reset) begin
      m_ok      = 1'b1;
      m_an      = 8'hFF;
      m_seg     = 7'h7F;
      m_last    = '1;
      m_last_oh = 1'b0;
      m_run     = 0;
      for (int i = 0; i < 8; i++) m_slot[i] = 4'h0;
      m_seen    = '0;
      m_pend    = 1'b0;
      m_to      = 0;
      m_frame   = '0;
      m_blank   = '0;
      m_fv      = 1'b0;
      m_einv    = 1'b0;
      m_emul    = 1'b0;
      m_stale   = 1'b0;
    end else begin
      m_fv = m_pend;
      if (m_pend) begin
        for (int i = 0; i < 8; i++) begin
          m_frame[4*i +: 4] = m_slot[i];
          m_blank[i]        = (m_slot[i] == 4'hF);
        end
      end
      zeros = 0;
      k     = 0;
      for (int i = 0; i < 8; i++) begin
        if (!m_an[i]) begin
          zeros++;
          k = i;
        end
      end
      cap  = 1'b0;
      code = m_decode(m_seg);
      if (zeros == 1) begin
        if (m_last_oh && ({m_an, m_seg} == m_last)) m_run++;
        else m_run = 1;
        cap       = (m_run == STABLE);
        m_last    = {m_an, m_seg};
        m_last_oh = 1'b1;
      end else begin
        m_last_oh = 1'b0;
        m_run     = 0;
      end
      if (cap) begin
        m_slot[k] = code;
        m_seen[k] = 1'b1;
      end
      done = (m_seen == 8'hFF);
      m_to++;
      tmo  = (m_to == TMO) && !done;
      if (done || tmo) begin
        m_seen = '0;
        m_to   = 0;
      end
      m_pend  = done;
      m_einv  = (m_einv && !clear) || (cap && code == 4'hE);
      m_emul  = (m_emul && !clear) || (zeros >= 2);
      m_stale = (m_stale && !clear) || tmo;
      m_an    = an;
      m_seg   = seg;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      checks++;
      if ({frame_out, frame_valid, blank_mask, err_invalid, err_multi, stale} !==
          {m_frame, m_fv, m_blank, m_einv, m_emul, m_stale}) begin
        failures++;
        $display("FAIL model cyc=%0d: dut frame=%h fv=%b blank=%h inv=%b multi=%b stale=%b; model frame=%h fv=%b blank=%h inv=%b multi=%b stale=%b",
                 cyc, frame_out, frame_valid, blank_mask, err_invalid, err_multi, stale,
                 m_frame, m_fv, m_blank, m_einv, m_emul, m_stale);
      end
    end
    if (frame_valid === 1'b1) begin
      fv_count++;
      fv_cyc   = cyc;
      fv_frame = frame_out;
      fv_blank = blank_mask;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear = 1'b0;
    an    = 8'hFF;
    seg   = 7'h7F;
    step(2);
    reset = 1'b0;
  endtask

  task automatic scan(input logic [31:0] vals, input int first, input int last, input int dwell);
    for (int d = first; d <= last; d++) begin
      if (d == 7) t7 = cyc;
      an  = ~(8'b1 << d);
      seg = enc(vals[4*d +: 4]);
      step(dwell);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    an    = 8'hFF;
    seg   = 7'h7F;

    // Reset values
    do_reset();
    chk("rst_frame_out", frame_out, 32'h0);
    chk("rst_blank_mask", blank_mask, 32'h0);
    chk("rst_flags", {frame_valid, err_invalid, err_multi, stale}, 32'h0);

    // Clean scan "12345678", 4 cycles per digit
    fv_count = 0;
    scan(32'h87654321, 0, 7, 4);
    an = 8'hFF; seg = 7'h7F;
    step(3);
    chk("clean_fv_count", fv_count, 1);
    chk("clean_frame", fv_frame, 32'h87654321);
    chk("clean_blank", fv_blank, 32'h00);
    chk("clean_latency", fv_cyc - t7, STABLE + 2);

    // One-cycle dwells never qualify; timeout fires at exactly 64 cycles
    do_reset();
    fv_count = 0;
    for (int c = 0; c < TMO - 1; c++) begin
      an  = ~(8'b1 << (c % 8));
      seg = pat[(c % 8) + 1];
      step(1);
    end
    chk("short_stale_at_63", stale, 0);
    an = 8'hFE; seg = pat[1];
    step(1);
    chk("short_stale_at_64", stale, 1);
    chk("short_fv_count", fv_count, 0);
    an = 8'hFF; seg = 7'h7F;

    // Invalid pattern on digit 3, then clear
    do_reset();
    fv_count = 0;
    scan(32'h8765E321, 0, 7, 4);
    an = 8'hFF; seg = 7'h7F;
    step(3);
    chk("inv_frame", fv_frame, 32'h8765E321);
    chk("inv_flag_set", err_invalid, 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
    chk("inv_flag_cleared", err_invalid, 0);
    chk("inv_frame_kept", frame_out, 32'h8765E321);

    // Two anodes low, then a frame with digit 7 blank
    do_reset();
    fv_count = 0;
    an = 8'b11111100; seg = pat[1];
    step(2);
    chk("multi_flag", err_multi, 1);
    scan(32'hF7654321, 0, 7, 4);
    an = 8'hFF; seg = 7'h7F;
    step(3);
    chk("blank_fv_count", fv_count, 1);
    chk("blank_frame", fv_frame, 32'hF7654321);
    chk("blank_mask", fv_blank, 32'h80);

    // Reset mid-frame discards partial data
    do_reset();
    fv_count = 0;
    scan(32'h99999999, 0, 4, 4);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    scan(32'h76543210, 0, 7, 4);
    an = 8'hFF; seg = 7'h7F;
    step(3);
    chk("midrst_fv_count", fv_count, 1);
    chk("midrst_frame", fv_frame, 32'h76543210);

    // Eighth capture coincides with the timeout: completion wins
    do_reset();
    fv_count = 0;
    scan(32'h12345678, 0, 6, 4);
    an = 8'hFF; seg = 7'h7F;
    step(TMO - 3 - 7 * 4);
    scan(32'h12345678, 7, 7, 4);
    an = 8'hFF; seg = 7'h7F;
    step(2);
    chk("race_fv_count", fv_count, 1);
    chk("race_frame", fv_frame, 32'h12345678);
    chk("race_stale", stale, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
